// File: rtl/wrap_counter_if.sv
// ---------------------------------------------------------------------------
// wrap_counter_if
//   Bundles the count-enable request and the counter's observable state so a
//   controller and the counter can be connected with one port.
//
//   Parameters
//     WIDTH     counter width in bits (1..32); must match the attached counter
//
//   Signals
//     enable    count enable, driven by the controller
//     count     current WIDTH-bit count, driven by the counter
//     overflow  high while count is all-ones, driven by the counter
//
//   Modports
//     master    controller side: drives enable, observes count/overflow
//     slave     counter side: observes enable, drives count/overflow
// ---------------------------------------------------------------------------
interface wrap_counter_if #(
    parameter int WIDTH = 8
);

    logic             enable;
    logic [WIDTH-1:0] count;
    logic             overflow;

    modport master (
        output enable,
        input  count,
        input  overflow
    );

    modport slave (
        input  enable,
        output count,
        output overflow
    );

endinterface

// File: rtl/wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
//   Free-running, enable-gated binary up-counter. The WIDTH-bit count wraps
//   modulo 2^WIDTH and overflow marks the terminal (all-ones) count so that
//   downstream logic can cascade counters or time fixed periods.
//
//   Parameters
//     WIDTH         counter width in bits (1..32)
//
//   Ports
//     clk           single clock, all state changes on the rising edge
//     rst           synchronous, active-high reset; beats enable
//     bus.enable    1 = increment on each rising clk edge, 0 = hold
//     bus.count     registered count value
//     bus.overflow  high while bus.count == all-ones
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    wrap_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;

    // Count register. Reset is checked first so a simultaneous enable is
    // ignored. The increment is plain WIDTH-bit unsigned arithmetic: the
    // carry out of the top bit is dropped, which gives the wrap from all-ones
    // back to zero with no saturation and no sticky state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.count = count_q;

    // Terminal-count flag is decoded straight from the register rather than
    // registered itself, so it follows the count exactly: it stays high while
    // the counter holds at all-ones and drops in the cycle the count wraps.
    // It does not depend on enable.
    assign bus.overflow = &count_q;

endmodule

// File: tb/tb_wrap_counter.sv
// ---------------------------------------------------------------------------
// tb_wrap_counter
//   Directed bench for wrap_counter at WIDTH = 8 with a 10 ns clock. Inputs
//   change just after a falling edge and outputs are sampled on the falling
//   edge, away from the rising edge where the counter updates. Expected
//   values are hand-computed constants or the loop index.
// ---------------------------------------------------------------------------
module tb_wrap_counter;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    wrap_counter_if #(.WIDTH(WIDTH)) bus_if ();

    wrap_counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive rst/enable, let the given number of rising edges pass, then park
    // on the following falling edge ready for sampling.
    task automatic apply_stimulus(input logic rst_v, input logic en_v, input int edges);
        rst           = rst_v;
        bus_if.enable = en_v;
        repeat (edges) @(posedge clk);
        @(negedge clk);
    endtask

    // Compare count and overflow against expected values.
    task automatic check_output(input string tag, input logic [WIDTH-1:0] exp_count,
                                input logic exp_overflow);
        checks++;
        assert (bus_if.count === exp_count)
        else begin
            failures++;
            $error("[TB] FAIL %s count observed=%0h expected=%0h", tag, bus_if.count, exp_count);
        end
        checks++;
        assert (bus_if.overflow === exp_overflow)
        else begin
            failures++;
            $error("[TB] FAIL %s overflow observed=%0b expected=%0b", tag, bus_if.overflow,
                   exp_overflow);
        end
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst           = 1'b1;
        bus_if.enable = 1'b0;

        // Reset with enable low, then held with enable high.
        apply_stimulus(1'b1, 1'b0, 2);
        check_output("reset_en0", 8'h00, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2);
        check_output("reset_en1", 8'h00, 1'b0);

        // Count up through 254.
        for (int i = 1; i <= 254; i++) begin
            apply_stimulus(1'b0, 1'b1, 1);
            check_output($sformatf("count_%0d", i), i[WIDTH-1:0], 1'b0);
        end

        // Terminal count, then wrap.
        apply_stimulus(1'b0, 1'b1, 1);
        check_output("terminal", 8'hFF, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1);
        check_output("wrap", 8'h00, 1'b0);

        // Hold at 0.
        apply_stimulus(1'b0, 1'b0, 2);
        check_output("hold_00", 8'h00, 1'b0);

        // Count to 5 and hold.
        apply_stimulus(1'b0, 1'b1, 5);
        check_output("count_to_05", 8'h05, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2);
        check_output("hold_05", 8'h05, 1'b0);

        // Count to all-ones and hold; overflow must stay high with enable low.
        apply_stimulus(1'b0, 1'b1, 250);
        check_output("count_to_ff", 8'hFF, 1'b1);
        apply_stimulus(1'b0, 1'b0, 2);
        check_output("hold_ff", 8'hFF, 1'b1);

        // From FF: one edge wraps to 0, 128 more reach 0x80.
        apply_stimulus(1'b0, 1'b1, 129);
        check_output("count_to_80", 8'h80, 1'b0);

        // Reset mid-count with enable high, then resume.
        apply_stimulus(1'b1, 1'b1, 1);
        check_output("reset_mid", 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1);
        check_output("resume", 8'h01, 1'b0);

        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
